// File: rtl/fixp_word_packer.sv
// Packs integer/fraction word pairs from a 32-bit stream into 64-bit 32.32 beats
// on a registered AXI-stream master, flagging odd-length frames.
module fixp_word_packer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  output logic [63:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_odd
);

  typedef enum logic {S_INT = 1'b0, S_FRAC = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] hi_reg;
  logic        s_hs;
  logic        m_hs;
  logic        int_take;
  logic        odd_hit;
  logic        frac_take;
  logic        out_free;

  // Handshake: a word transfers on s_tvalid & s_tready, a beat on m_tvalid & m_tready;
  // s_tready never looks at s_tvalid, and in S_FRAC it waits for room in the output register.
  assign out_free = !m_tvalid | m_tready;
  assign m_hs     = m_tvalid & m_tready;

  always_comb begin
    state_nxt = state;
    s_tready  = 1'b1;
    if (state == S_FRAC) s_tready = out_free;
    s_hs      = s_tvalid & s_tready;
    int_take  = s_hs & (state == S_INT) & !s_tlast;
    odd_hit   = s_hs & (state == S_INT) & s_tlast;
    frac_take = s_hs & (state == S_FRAC);
    if (int_take)  state_nxt = S_FRAC;
    if (frac_take) state_nxt = S_INT;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_INT;
      hi_reg    <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      err_odd   <= 1'b0;
      pair_cnt  <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state   <= state_nxt;
      err_odd <= odd_hit;
      if (int_take) hi_reg <= s_tdata;
      // A reload in the same cycle as an unload keeps m_tvalid high with no bubble.
      if (frac_take) begin
        m_tdata  <= {hi_reg, s_tdata};
        m_tvalid <= 1'b1;
        m_tlast  <= s_tlast;
      end else if (m_hs) begin
        m_tvalid <= 1'b0;
      end
      if (m_hs)            pair_cnt  <= pair_cnt + 1'b1;
      if (s_hs && s_tlast) frame_cnt <= frame_cnt + 1'b1;
      if (odd_hit)         err_cnt   <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fixp_word_packer.sv
// Directed bench for fixp_word_packer: pairing, sign pass-through, backpressure,
// odd frames, mid-pair reset and full-rate streaming.
module tb_fixp_word_packer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [31:0] pair_cnt, frame_cnt, err_cnt;
  logic        err_odd;

  int tests = 0;
  int fails = 0;
  bit rand_rdy = 1'b0;

  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  int          stall_cnt;
  int          bad_rdy;
  int          err_pulses;
  bit          phase;

  fixp_word_packer #(.CNT_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .pair_cnt(pair_cnt), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .err_odd(err_odd)
  );

  always #5 clk = ~clk;

  // Monitor: collects beats, counts stalls and checks s_tready against a word-phase model.
  always @(posedge clk) begin
    if (!rstn) begin
      got_q.delete();
      stall_cnt  <= 0;
      bad_rdy    <= 0;
      err_pulses <= 0;
      phase      <= 1'b0;
    end else begin
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
      if (s_tvalid && !s_tready) stall_cnt <= stall_cnt + 1;
      if (err_odd) err_pulses <= err_pulses + 1;
      if (phase == 1'b0 && !s_tready) bad_rdy <= bad_rdy + 1;
      if (phase == 1'b1 && s_tready !== (!m_tvalid || m_tready)) bad_rdy <= bad_rdy + 1;
      if (s_tvalid && s_tready) begin
        if (phase == 1'b0 && s_tlast) phase <= 1'b0;
        else phase <= ~phase;
      end
    end
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit hs = 1'b0;
    @(negedge clk);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    for (int k = 0; k < 200; k++) begin
      if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
      #1;
      if (s_tready) begin
        hs = 1'b1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!hs) check("send_timeout", 65'(hs), 65'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    rand_rdy = 1'b0;
    m_tready = 1'b1;
    for (int k = 0; k < 300 && got_q.size() < n; k++) @(negedge clk);
    check({tag, "_beat_count"}, 65'(got_q.size()), 65'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check({tag, "_beat"}, got_q[i], exp_q[i]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m_tvalid"}, 65'(m_tvalid), 65'd0);
    check({tag, "_m_tdata"}, 65'(m_tdata), 65'd0);
    check({tag, "_m_tlast"}, 65'(m_tlast), 65'd0);
    check({tag, "_err_odd"}, 65'(err_odd), 65'd0);
    check({tag, "_pair_cnt"}, 65'(pair_cnt), 65'd0);
    check({tag, "_frame_cnt"}, 65'(frame_cnt), 65'd0);
    check({tag, "_err_cnt"}, 65'(err_cnt), 65'd0);
    check({tag, "_s_tready"}, 65'(s_tready), 65'd1);
  endtask

  initial begin
    logic [31:0] a, b;

    // Reset state
    do_reset();
    check_zero("reset");

    // Pair packing: beat visible the cycle after the fraction accept
    send(32'h0000_0005, 1'b0);
    send(32'h8000_0000, 1'b1);
    idle();
    check("pack_valid", 65'(m_tvalid), 65'd1);
    check("pack_data", 65'(m_tdata), 65'h00000005_80000000);
    check("pack_last", 65'(m_tlast), 65'd1);
    @(negedge clk);
    check("pack_pair_cnt", 65'(pair_cnt), 65'd1);
    check("pack_frame_cnt", 65'(frame_cnt), 65'd1);
    check("pack_valid_clear", 65'(m_tvalid), 65'd0);

    // Negative integer passes through bit-exact
    send(32'hFFFF_FFFE, 1'b0);
    send(32'h4000_0000, 1'b0);
    idle();
    check("neg_data", 65'(m_tdata), 65'hFFFFFFFE_40000000);
    check("neg_last", 65'(m_tlast), 65'd0);

    // Backpressure: 8 random pairs with random m_tready
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      exp_q.push_back({i == 7, a, b});
      send(a, 1'b0);
      send(b, i == 7);
    end
    idle();
    drain("bp");
    check("bp_ready_rule", 65'(bad_rdy), 65'd0);
    check("bp_pair_cnt", 65'(pair_cnt), 65'd8);

    // Odd frame: A,B,C(last) then D,E(last)
    do_reset();
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    send(32'h3333_3333, 1'b1);
    idle();
    check("odd_pulse", 65'(err_odd), 65'd1);
    check("odd_err_cnt", 65'(err_cnt), 65'd1);
    check("odd_frame_cnt", 65'(frame_cnt), 65'd1);
    @(negedge clk);
    check("odd_pulse_end", 65'(err_odd), 65'd0);
    exp_q.push_back({1'b0, 32'h1111_1111, 32'h2222_2222});
    exp_q.push_back({1'b1, 32'h4444_4444, 32'h5555_5555});
    send(32'h4444_4444, 1'b0);
    send(32'h5555_5555, 1'b1);
    idle();
    drain("odd");
    @(negedge clk);
    check("odd_pulses", 65'(err_pulses), 65'd1);
    check("odd_frame_cnt2", 65'(frame_cnt), 65'd2);
    check("odd_err_cnt2", 65'(err_cnt), 65'd1);

    // Reset mid-pair drops the held integer word
    do_reset();
    send(32'hDEAD_BEEF, 1'b0);
    do_reset();
    check_zero("midrst");
    exp_q.push_back({1'b1, 32'h0000_00F0, 32'h0000_0A0A});
    send(32'h0000_00F0, 1'b0);
    send(32'h0000_0A0A, 1'b1);
    idle();
    drain("midrst");

    // Full-rate streaming: 1000 words, no stalls
    do_reset();
    for (int i = 0; i < 500; i++) begin
      a = $urandom;
      b = $urandom;
      exp_q.push_back({i == 499, a, b});
      send(a, 1'b0);
      send(b, i == 499);
    end
    idle();
    drain("stream");
    @(negedge clk);
    check("stream_stalls", 65'(stall_cnt), 65'd0);
    check("stream_pair_cnt", 65'(pair_cnt), 65'd500);
    check("stream_frame_cnt", 65'(frame_cnt), 65'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
